// File: rtl/snake_pkg.sv
// Shared definitions for the snake game direction handling.
// Heading codes, heading type and the reversal helper are used both by the
// direction controller and by the movement/collision logic.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_RIGHT = 2'd1;
  localparam dir_t DIR_DOWN  = 2'd2;
  localparam dir_t DIR_LEFT  = 2'd3;

  // Opposite headings differ only in the upper code bit.
  function automatic dir_t opposite(input dir_t d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small synchronous FIFO holding queued snake headings.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   push        - write wr_data (ignored when full unless pop in same cycle)
//   pop         - remove head entry (ignored when empty)
//   wr_data     - heading to enqueue
//   head_data   - oldest queued heading
//   tail_data   - most recently queued heading (valid when not empty)
//   count       - number of queued entries, 0..DEPTH
//   full, empty - occupancy flags
module dir_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  dir_t             wr_data,
  output dir_t             head_data,
  output dir_t             tail_data,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  dir_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A full queue may still accept a write when the head leaves in the same
  // cycle: the freed slot is exactly the one the write pointer targets.
  assign wr_ok = push && (!full || pop);
  assign rd_ok = pop && !empty;

  assign tail_ptr  = wr_ptr - PTR_ONE;
  assign head_data = mem[rd_ptr];
  assign tail_data = mem[tail_ptr];

  // Storage has no reset; validity is tracked purely by count.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally modulo DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Direction controller for the snake game.
// Turns debounced direction-button levels into queued heading changes and
// applies one queued heading per game step.
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   btn_up/right/down/left - debounced button levels, 1 = pressed
//   step                - one-cycle game advance pulse, consumes one turn
//   dir                 - current heading (UP=0 RIGHT=1 DOWN=2 LEFT=3)
//   q_count             - number of pending turns, 0..DEPTH
//   drop                - one-cycle pulse when an acceptable turn found the queue full
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int   DEPTH    = 4,
  parameter int   PTR_W    = 2,
  parameter dir_t INIT_DIR = DIR_RIGHT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           btn_up,
  input  logic           btn_right,
  input  logic           btn_down,
  input  logic           btn_left,
  input  logic           step,
  output dir_t           dir,
  output logic [PTR_W:0] q_count,
  output logic           drop
);

  logic [3:0] btn_now;
  logic [3:0] btn_prev;
  logic [3:0] press;
  logic       cand_valid;
  dir_t       cand;
  dir_t       tail;
  logic       accept;
  logic       drop_next;
  dir_t       head_data;
  dir_t       tail_data;
  logic       q_full;
  logic       q_empty;

  // Bit order follows pick priority: [3]=UP, [2]=RIGHT, [1]=DOWN, [0]=LEFT.
  assign btn_now = {btn_up, btn_right, btn_down, btn_left};
  assign press   = btn_now & ~btn_prev;

  // Previous levels reset to 1 so a button held through reset is not seen
  // as a fresh press when reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_prev <= 4'hF;
    end else begin
      btn_prev <= btn_now;
    end
  end

  // Only the highest-priority new press becomes a candidate; others are lost.
  always_comb begin
    cand_valid = 1'b1;
    cand       = DIR_UP;
    if (press[3]) begin
      cand = DIR_UP;
    end else if (press[2]) begin
      cand = DIR_RIGHT;
    end else if (press[1]) begin
      cand = DIR_DOWN;
    end else if (press[0]) begin
      cand = DIR_LEFT;
    end else begin
      cand_valid = 1'b0;
    end
  end

  // A turn is judged against the heading the snake will have once everything
  // already queued has been applied. When the only entry is being popped this
  // cycle it is still the FIFO tail, which is also the heading it becomes.
  always_comb begin
    tail      = q_empty ? dir : tail_data;
    accept    = cand_valid && (cand != tail) && (cand != opposite(tail));
    drop_next = accept && q_full && !step;
  end

  dir_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .pop       (step),
    .wr_data   (cand),
    .head_data (head_data),
    .tail_data (tail_data),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Heading register and drop pulse; a step with nothing queued keeps dir.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir  <= INIT_DIR;
      drop <= 1'b0;
    end else begin
      drop <= drop_next;
      if (step && !q_empty) begin
        dir <= head_data;
      end
    end
  end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed self-checking bench for snake_dir_ctrl.
module tb_snake_dir_ctrl;
  import snake_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up, btn_right, btn_down, btn_left;
  logic       step;
  dir_t       dir;
  logic [2:0] q_count;
  logic       drop;

  int tests_run = 0;
  int failed    = 0;

  snake_dir_ctrl #(.DEPTH(4), .PTR_W(2), .INIT_DIR(DIR_RIGHT)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_right (btn_right),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .step      (step),
    .dir       (dir),
    .q_count   (q_count),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the four buttons as {up,right,down,left}.
  task automatic set_btns(input logic [3:0] b);
    {btn_up, btn_right, btn_down, btn_left} = b;
  endtask

  // One-cycle press followed by one-cycle release.
  task automatic press(input logic [3:0] b);
    set_btns(b);
    tick();
    set_btns(4'b0000);
    tick();
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic do_reset();
    set_btns(4'b0000);
    step  = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    set_btns(4'b1000);
    step  = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tests_run++;
    if (q_count !== 3'd0 || dir !== DIR_RIGHT || drop !== 1'b0) begin
      $display("[TB] FAIL reset_state q_count=%0d dir=%0d drop=%b, want 0/1/0", q_count, dir, drop);
      failed++;
    end
    set_btns(4'b0000);
    tick();
    tests_run++;
    if (q_count !== 3'd0) begin
      $display("[TB] FAIL held_release q_count=%0d, want 0", q_count);
      failed++;
    end
    set_btns(4'b1000);
    tick();
    tests_run++;
    if (q_count !== 3'd1) begin
      $display("[TB] FAIL repress q_count=%0d, want 1", q_count);
      failed++;
    end
    set_btns(4'b0000);
    tick();
  endtask

  task automatic test_queue_reject();
    do_reset();
    press(4'b0010);
    press(4'b0001);
    tests_run++;
    if (q_count !== 3'd2) begin
      $display("[TB] FAIL queue_two q_count=%0d, want 2", q_count);
      failed++;
    end
    set_btns(4'b0100);
    tick();
    tests_run++;
    if (q_count !== 3'd2 || drop !== 1'b0) begin
      $display("[TB] FAIL reverse_reject q_count=%0d drop=%b, want 2/0", q_count, drop);
      failed++;
    end
    set_btns(4'b0000);
    tick();
    press(4'b1000);
    tests_run++;
    if (q_count !== 3'd3) begin
      $display("[TB] FAIL up_from_left q_count=%0d, want 3", q_count);
      failed++;
    end
    do_step();
    tests_run++;
    if (dir !== DIR_DOWN || q_count !== 3'd2) begin
      $display("[TB] FAIL pop1 dir=%0d q_count=%0d, want 2/2", dir, q_count);
      failed++;
    end
    do_step();
    do_step();
    tests_run++;
    if (dir !== DIR_UP || q_count !== 3'd0) begin
      $display("[TB] FAIL pop3 dir=%0d q_count=%0d, want 0/0", dir, q_count);
      failed++;
    end
  endtask

  task automatic test_null_turn();
    do_reset();
    press(4'b0001);
    press(4'b0100);
    tests_run++;
    if (q_count !== 3'd0) begin
      $display("[TB] FAIL null_turn q_count=%0d, want 0", q_count);
      failed++;
    end
    do_step();
    tests_run++;
    if (dir !== DIR_RIGHT || q_count !== 3'd0) begin
      $display("[TB] FAIL null_step dir=%0d q_count=%0d, want 1/0", dir, q_count);
      failed++;
    end
  endtask

  task automatic test_full_drop();
    do_reset();
    press(4'b1000);
    press(4'b0001);
    press(4'b0010);
    press(4'b0100);
    tests_run++;
    if (q_count !== 3'd4) begin
      $display("[TB] FAIL fill q_count=%0d, want 4", q_count);
      failed++;
    end
    set_btns(4'b1000);
    tick();
    tests_run++;
    if (drop !== 1'b1 || q_count !== 3'd4) begin
      $display("[TB] FAIL drop_pulse drop=%b q_count=%0d, want 1/4", drop, q_count);
      failed++;
    end
    set_btns(4'b0000);
    tick();
    tests_run++;
    if (drop !== 1'b0) begin
      $display("[TB] FAIL drop_clear drop=%b, want 0", drop);
      failed++;
    end
    set_btns(4'b1000);
    step = 1'b1;
    tick();
    set_btns(4'b0000);
    step = 1'b0;
    tests_run++;
    if (drop !== 1'b0 || q_count !== 3'd4 || dir !== DIR_UP) begin
      $display("[TB] FAIL full_push_pop drop=%b q_count=%0d dir=%0d, want 0/4/0", drop, q_count, dir);
      failed++;
    end
    do_step();
    tests_run++;
    if (dir !== DIR_LEFT) begin
      $display("[TB] FAIL wrap_pop1 dir=%0d, want 3", dir);
      failed++;
    end
    do_step();
    do_step();
    do_step();
    tests_run++;
    if (dir !== DIR_UP || q_count !== 3'd0) begin
      $display("[TB] FAIL wrap_pop4 dir=%0d q_count=%0d, want 0/0", dir, q_count);
      failed++;
    end
  endtask

  task automatic test_priority();
    do_reset();
    press(4'b1001);
    tests_run++;
    if (q_count !== 3'd1 || drop !== 1'b0) begin
      $display("[TB] FAIL priority_count q_count=%0d drop=%b, want 1/0", q_count, drop);
      failed++;
    end
    do_step();
    tests_run++;
    if (dir !== DIR_UP || q_count !== 3'd0) begin
      $display("[TB] FAIL priority_dir dir=%0d q_count=%0d, want 0/0", dir, q_count);
      failed++;
    end
  endtask

  task automatic test_empty_step();
    do_reset();
    do_step();
    tests_run++;
    if (dir !== DIR_RIGHT || q_count !== 3'd0) begin
      $display("[TB] FAIL empty_step dir=%0d q_count=%0d, want 1/0", dir, q_count);
      failed++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    press(4'b0010);
    set_btns(4'b0001);
    step = 1'b1;
    tick();
    set_btns(4'b0000);
    step = 1'b0;
    tests_run++;
    if (dir !== DIR_DOWN || q_count !== 3'd1) begin
      $display("[TB] FAIL step_push dir=%0d q_count=%0d, want 2/1", dir, q_count);
      failed++;
    end
    do_step();
    tests_run++;
    if (dir !== DIR_LEFT || q_count !== 3'd0) begin
      $display("[TB] FAIL step_push_next dir=%0d q_count=%0d, want 3/0", dir, q_count);
      failed++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press(4'b1000);
    press(4'b0001);
    press(4'b0010);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if (q_count !== 3'd0 || dir !== DIR_RIGHT || drop !== 1'b0) begin
      $display("[TB] FAIL reset_mid q_count=%0d dir=%0d drop=%b, want 0/1/0", q_count, dir, drop);
      failed++;
    end
    tick();
    do_step();
    tests_run++;
    if (dir !== DIR_RIGHT) begin
      $display("[TB] FAIL reset_mid_step dir=%0d, want 1", dir);
      failed++;
    end
  endtask

  initial begin
    reset = 1'b1;
    step  = 1'b0;
    set_btns(4'b0000);
    test_reset();
    test_queue_reject();
    test_null_turn();
    test_full_drop();
    test_priority();
    test_empty_step();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
